// File: rtl/mem_sweep_ctrl.sv
// mem_sweep_ctrl: arbiter and FILL/VERIFY sweep engine for one simple-dual-port RAM.
// Define MEM_SWEEP_ERR_LOG_EN to build the first-mismatch address/data capture.
module mem_sweep_ctrl #(
    parameter int WID_MEM   = 16,
    parameter int DEPTH_MEM = 1024,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_start,
    input  logic               cmd_op,
    input  logic [WID_MEM-1:0] fill_value,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [31:0]        err_addr,
    output logic [WID_MEM-1:0] err_data,
    input  logic               usr_req,
    input  logic               usr_we,
    input  logic [31:0]        usr_addr,
    input  logic [WID_MEM-1:0] usr_wdata,
    output logic               usr_gnt,
    output logic               usr_rvalid,
    output logic [WID_MEM-1:0] usr_rdata,
    output logic [31:0]        mem_raddr,
    output logic [31:0]        mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic               mem_we,
    input  logic [WID_MEM-1:0] mem_dout
);
    localparam int AW = $clog2(DEPTH_MEM);
    localparam logic [AW-1:0] SA_LAST = AW'(DEPTH_MEM - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_VERIFY, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nx;
    logic [AW-1:0]      sa, sa_nx;
    logic [WID_MEM-1:0] fill_q;
    logic               sweep_wr, sweep_rd;
    logic               rd_pend;
    logic               usr_rd_q;
    logic               start_verify;
    logic               mismatch;
    logic [31:0]        raddr_q, waddr_q;
    logic [WID_MEM-1:0] din_q;

    assign start_verify = (state == S_IDLE) && cmd_start && cmd_op;
    assign mismatch     = rd_pend && (mem_dout != fill_q);

    always_comb begin
        state_nx = state;
        sa_nx    = sa;
        sweep_wr = 1'b0;
        sweep_rd = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    state_nx = cmd_op ? S_VERIFY : S_FILL;
                    sa_nx    = '0;
                end
            end
            S_FILL: begin
                if (!usr_req) begin
                    sweep_wr = 1'b1;
                    if (sa == SA_LAST) state_nx = S_DONE;
                    else               sa_nx    = sa + 1'b1;
                end
            end
            S_VERIFY: begin
                if (!usr_req) begin
                    sweep_rd = 1'b1;
                    if (sa == SA_LAST) state_nx = S_DRAIN;
                    else               sa_nx    = sa + 1'b1;
                end
            end
            // A granted user cycle stalls the drain too, so every grant costs one cycle.
            S_DRAIN: if (!usr_req) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr_q;
        mem_raddr = raddr_q;
        mem_din   = din_q;
        if (usr_req) begin
            if (usr_we) begin
                mem_we    = 1'b1;
                mem_waddr = usr_addr;
                mem_din   = usr_wdata;
            end else begin
                mem_raddr = usr_addr;
            end
        end else if (sweep_wr) begin
            mem_we    = 1'b1;
            mem_waddr = 32'(sa);
            mem_din   = fill_q;
        end else if (sweep_rd) begin
            mem_raddr = 32'(sa);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            sa       <= '0;
            fill_q   <= '0;
            rd_pend  <= 1'b0;
            usr_rd_q <= 1'b0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            din_q    <= '0;
            err_cnt  <= '0;
        end else begin
            state    <= state_nx;
            sa       <= sa_nx;
            rd_pend  <= sweep_rd;
            usr_rd_q <= usr_req && !usr_we;
            raddr_q  <= mem_raddr;
            waddr_q  <= mem_waddr;
            din_q    <= mem_din;
            if (state == S_IDLE && cmd_start) begin
                fill_q <= fill_value;
                if (cmd_op) err_cnt <= '0;
            end else if (mismatch && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign usr_gnt    = usr_req;
    assign usr_rvalid = usr_rd_q;
    assign usr_rdata  = usr_rd_q ? mem_dout : '0;
    assign busy       = (state == S_FILL) || (state == S_VERIFY) || (state == S_DRAIN);
    assign done       = (state == S_DONE);

`ifdef MEM_SWEEP_ERR_LOG_EN
    logic [AW-1:0]      rd_addr;
    logic               err_seen;
    logic [31:0]        err_addr_q;
    logic [WID_MEM-1:0] err_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr    <= '0;
            err_seen   <= 1'b0;
            err_addr_q <= '0;
            err_data_q <= '0;
        end else begin
            rd_addr <= sa;
            if (start_verify) begin
                err_seen   <= 1'b0;
                err_addr_q <= '0;
                err_data_q <= '0;
            end else if (mismatch && !err_seen) begin
                err_seen   <= 1'b1;
                err_addr_q <= 32'(rd_addr);
                err_data_q <= mem_dout;
            end
        end
    end

    assign err_addr = err_addr_q;
    assign err_data = err_data_q;
`else
    logic unused_log;
    assign unused_log = start_verify;
    assign err_addr   = '0;
    assign err_data   = '0;
`endif
endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Self-checking bench for mem_sweep_ctrl: RAM models plus a contents/latency reference model.
module tb_mem_sweep_ctrl;
    localparam int D = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0, cmd_op = 1'b0;
    logic [15:0] fill_value = '0;
    logic        busy, done;
    logic [15:0] err_cnt;
    logic [31:0] err_addr;
    logic [15:0] err_data;
    logic        usr_req = 1'b0, usr_we = 1'b0;
    logic [31:0] usr_addr = '0;
    logic [15:0] usr_wdata = '0;
    logic        usr_gnt, usr_rvalid;
    logic [15:0] usr_rdata;
    logic [31:0] mem_raddr, mem_waddr;
    logic [15:0] mem_din, mem_dout;
    logic        mem_we;

    logic        start_s = 1'b0, busy_s, done_s, gnt_s, rv_s, we_s;
    logic [3:0]  cnt_s;
    logic [31:0] ea_s, ra_s, wa_s;
    logic [15:0] ed_s, rd_s, di_s, do_s;
    logic        start_t = 1'b0, busy_t, done_t, gnt_t, rv_t, we_t;
    logic [3:0]  cnt_t;
    logic [31:0] ea_t, ra_t, wa_t;
    logic [15:0] ed_t, rd_t, di_t, do_t;

    logic [15:0] ram_m [D];
    logic [15:0] ram_s [32];
    logic [15:0] ram_t [2];
    logic [15:0] ref_m [D];

    int checks = 0, errors = 0;
    int wr_t = 0;
    logic bad_t = 1'b0;

    always #5 clk = ~clk;

    mem_sweep_ctrl #(.WID_MEM(16), .DEPTH_MEM(D), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_op(cmd_op), .fill_value(fill_value),
        .busy(busy), .done(done), .err_cnt(err_cnt), .err_addr(err_addr), .err_data(err_data),
        .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
        .usr_gnt(usr_gnt), .usr_rvalid(usr_rvalid), .usr_rdata(usr_rdata),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout));

    mem_sweep_ctrl #(.WID_MEM(16), .DEPTH_MEM(32), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .cmd_start(start_s), .cmd_op(cmd_op), .fill_value(fill_value),
        .busy(busy_s), .done(done_s), .err_cnt(cnt_s), .err_addr(ea_s), .err_data(ed_s),
        .usr_req(1'b0), .usr_we(1'b0), .usr_addr(32'd0), .usr_wdata(16'd0),
        .usr_gnt(gnt_s), .usr_rvalid(rv_s), .usr_rdata(rd_s),
        .mem_raddr(ra_s), .mem_waddr(wa_s), .mem_din(di_s), .mem_we(we_s), .mem_dout(do_s));

    mem_sweep_ctrl #(.WID_MEM(16), .DEPTH_MEM(2), .CNT_W(4)) dut_t (
        .clk(clk), .reset(reset), .cmd_start(start_t), .cmd_op(cmd_op), .fill_value(fill_value),
        .busy(busy_t), .done(done_t), .err_cnt(cnt_t), .err_addr(ea_t), .err_data(ed_t),
        .usr_req(1'b0), .usr_we(1'b0), .usr_addr(32'd0), .usr_wdata(16'd0),
        .usr_gnt(gnt_t), .usr_rvalid(rv_t), .usr_rdata(rd_t),
        .mem_raddr(ra_t), .mem_waddr(wa_t), .mem_din(di_t), .mem_we(we_t), .mem_dout(do_t));

    // RAM models: synchronous write, registered one-cycle read.
    always @(posedge clk) begin
        if (mem_we && mem_waddr < D) ram_m[mem_waddr[9:0]] <= mem_din;
        mem_dout <= (mem_raddr < D) ? ram_m[mem_raddr[9:0]] : 16'hDEAD;
        if (we_s && wa_s < 32) ram_s[wa_s[4:0]] <= di_s;
        do_s <= (ra_s < 32) ? ram_s[ra_s[4:0]] : 16'hDEAD;
        if (we_t && wa_t < 2) ram_t[wa_t[0]] <= di_t;
        do_t <= (ra_t < 2) ? ram_t[ra_t[0]] : 16'hDEAD;
        if (!reset && we_t) begin
            wr_t++;
            if (wa_t >= 2) bad_t = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_errcnt"}, err_cnt, 0);
        check({tag, "_erraddr"}, err_addr, 0);
        check({tag, "_errdata"}, err_data, 0);
        check({tag, "_rvalid"}, usr_rvalid, 0);
        check({tag, "_rdata"}, usr_rdata, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_raddr"}, mem_raddr, 0);
        check({tag, "_waddr"}, mem_waddr, 0);
        check({tag, "_din"}, mem_din, 0);
    endtask

    // Runs one main-DUT sweep with an optional user read burst and an optional ignored start.
    task automatic sweep(input logic op, input logic [15:0] val, input int ustart, input int ulen,
                         input logic [31:0] uaddr, input int ign_at, input string tag);
        int   lat = -1;
        int   grants = 0;
        int   nbad = 0;
        int   fb = -1;
        logic prev_rd = 1'b0;
        @(posedge clk); #1;
        cmd_start = 1'b1; cmd_op = op; fill_value = val;
        for (int c = 1; c < D + 200 && lat < 0; c++) begin
            @(posedge clk); #1;
            cmd_start = (c == ign_at);
            if (c == ign_at) begin
                cmd_op = ~op; fill_value = ~val;
            end
            usr_req = (c >= ustart) && (c < ustart + ulen);
            usr_we = 1'b0; usr_addr = uaddr;
            if (usr_req) grants++;
            @(negedge clk);
            if (c == 1) check({tag, "_busy_rise"}, busy, 1);
            check({tag, "_rvalid"}, usr_rvalid, prev_rd);
            if (prev_rd && op) check({tag, "_rdata"}, usr_rdata, ref_m[uaddr[9:0]]);
            prev_rd = usr_req;
            if (done) begin
                lat = c;
                check({tag, "_busy_fall"}, busy, 0);
            end
        end
        cmd_start = 1'b0; usr_req = 1'b0;
        check({tag, "_latency"}, lat, D + 1 + int'(op) + grants);
        if (!op) begin
            for (int a = 0; a < D; a++) ref_m[a] = val;
        end else begin
            for (int a = 0; a < D; a++)
                if (ref_m[a] !== val) begin
                    if (fb < 0) fb = a;
                    nbad++;
                end
            check({tag, "_errcnt"}, err_cnt, (nbad > 65535) ? 65535 : nbad);
`ifdef MEM_SWEEP_ERR_LOG_EN
            check({tag, "_erraddr"}, err_addr, (fb < 0) ? 0 : fb);
            check({tag, "_errdata"}, err_data, (fb < 0) ? 16'h0 : ref_m[fb]);
`else
            check({tag, "_erraddr"}, err_addr, 0);
            check({tag, "_errdata"}, err_data, 0);
`endif
        end
    endtask

    // User write, read-back on the very next cycle, then an idle cycle.
    task automatic usr_write(input logic [31:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        usr_req = 1'b1; usr_we = 1'b1; usr_addr = a; usr_wdata = d;
        @(negedge clk);
        check("uw_gnt", usr_gnt, 1);
        check("uw_we", mem_we, 1);
        check("uw_waddr", mem_waddr, a);
        check("uw_din", mem_din, d);
        @(posedge clk); #1;
        usr_we = 1'b0;
        @(negedge clk);
        check("ur_raddr", mem_raddr, a);
        @(posedge clk); #1;
        usr_req = 1'b0;
        @(negedge clk);
        check("ur_rvalid", usr_rvalid, 1);
        check("ur_rdata", usr_rdata, d);
        check("idle_we", mem_we, 0);
        check("idle_waddr", mem_waddr, a);
        check("idle_raddr", mem_raddr, a);
        ref_m[a[9:0]] = d;
    endtask

    task automatic small_sweep(input int which, input logic op, input logic [15:0] val,
                               input int exp_lat, input string tag);
        int lat = -1;
        @(posedge clk); #1;
        cmd_op = op; fill_value = val;
        if (which == 0) start_s = 1'b1;
        else            start_t = 1'b1;
        for (int c = 1; c < 200 && lat < 0; c++) begin
            @(posedge clk); #1;
            start_s = 1'b0; start_t = 1'b0;
            @(negedge clk);
            if ((which == 0) ? done_s : done_t) lat = c;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        logic [15:0] v, v2;
        int          nw, done_seen;
        for (int a = 0; a < D; a++) begin
            ram_m[a] = '0; ref_m[a] = '0;
        end
        for (int a = 0; a < 32; a++) ram_s[a] = '0;
        ram_t[0] = '0; ram_t[1] = '0;

        @(negedge clk);
        check_reset_vals("rst0");
        check("rst0_busy_s", busy_s, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        sweep(1'b0, 16'hA5A5, 0, 0, 0, 40, "fill_a5");
        sweep(1'b1, 16'hA5A5, 0, 0, 0, 0, "ver_a5");

        sweep(1'b0, 16'h0000, 0, 0, 0, 0, "fill_0");
        usr_write(32'd5, 16'h1234);
        usr_write(32'd900, 16'h1234);
        sweep(1'b1, 16'h0000, 0, 0, 0, 0, "ver_0");
        sweep(1'b1, 16'h0000, 100 + int'($urandom_range(0, 400)), 10, 32'd3, 0, "ver_usr");

        for (int r = 0; r < 3; r++) begin
            v = 16'($urandom);
            sweep(1'b0, v, int'($urandom_range(2, D - 100)), int'($urandom_range(0, 15)),
                  32'($urandom_range(0, D - 1)), 0, "rnd_fill");
            nw = int'($urandom_range(0, 4));
            for (int k = 0; k < nw; k++)
                usr_write(32'($urandom_range(0, D - 1)), 16'($urandom));
            v2 = ($urandom_range(0, 1) == 1) ? v : 16'($urandom);
            sweep(1'b1, v2, int'($urandom_range(2, D - 100)), int'($urandom_range(1, 20)),
                  32'($urandom_range(0, D - 1)), 0, "rnd_ver");
        end

        small_sweep(0, 1'b0, 16'h0000, 33, "s_fill");
        small_sweep(0, 1'b1, 16'hFFFF, 34, "s_ver");
        check("s_errcnt_sat", cnt_s, 15);

        small_sweep(1, 1'b0, 16'hC3C3, 3, "t_fill");
        check("t_writes", wr_t, 2);
        check("t_oob_write", bad_t, 0);
        check("t_ram0", ram_t[0], 16'hC3C3);
        check("t_ram1", ram_t[1], 16'hC3C3);

        // Reset in the middle of a FILL, while sa is 300.
        @(posedge clk); #1;
        cmd_start = 1'b1; cmd_op = 1'b0; fill_value = 16'h5555;
        for (int c = 1; c <= 301; c++) begin
            @(posedge clk); #1;
            cmd_start = 1'b0;
        end
        @(negedge clk);
        check("mid_sa", mem_waddr, 300);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("post_rst_quiet", done_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
